// File: rtl/lc3b_control.sv
// lc3b_types: shared opcode and ALU operation encodings for the LC-3b datapath.
//
// lc3b_control: multicycle Moore control FSM for the LC-3b datapath. It sequences
// fetch, decode and execute for ADD, AND, NOT, BR, JMP, LDR and STR, and owns the
// handshake with the single-ported memory.
//
// Ports
//   i_clk              system clock, rising edge
//   i_reset            asynchronous active-high reset; holds FETCH1 and gates all outputs to 0
//   i_opcode           IR[15:12], sampled in DECODE and CALC_ADDR only
//   i_branch_enable    nzp comparator result, sampled in BR only
//   i_mem_resp         one-cycle memory completion pulse
//   o_load_*           register load enables (PC, IR, regfile, MAR, MDR, CC)
//   o_pcmux_sel        00 PC+2, 01 PC+offset9, 10 BaseR
//   o_storemux_sel     0 SR1 = IR[8:6], 1 SR1 = IR[11:9]
//   o_alumux_sel       0 SR2, 1 sext(offset6)<<1
//   o_regfilemux_sel   0 ALU out, 1 MDR
//   o_marmux_sel       0 ALU out, 1 PC
//   o_mdrmux_sel       0 ALU out, 1 mem_rdata
//   o_aluop            ALU operation
//   o_mem_read/write   memory strobes, held through wait cycles
//   o_mem_byte_enable  2'b11 outside reset (word accesses only)

package lc3b_types;

    typedef logic [3:0] lc3b_opcode;
    typedef logic [2:0] lc3b_aluop;

    localparam lc3b_opcode OpBr  = 4'b0000;
    localparam lc3b_opcode OpAdd = 4'b0001;
    localparam lc3b_opcode OpAnd = 4'b0101;
    localparam lc3b_opcode OpLdr = 4'b0110;
    localparam lc3b_opcode OpStr = 4'b0111;
    localparam lc3b_opcode OpNot = 4'b1001;
    localparam lc3b_opcode OpJmp = 4'b1100;

    localparam lc3b_aluop AluAdd  = 3'b000;
    localparam lc3b_aluop AluAnd  = 3'b001;
    localparam lc3b_aluop AluNot  = 3'b010;
    localparam lc3b_aluop AluPass = 3'b011;

endpackage

module lc3b_control
    import lc3b_types::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_opcode,
    input  logic       i_branch_enable,
    input  logic       i_mem_resp,
    output logic       o_load_pc,
    output logic       o_load_ir,
    output logic       o_load_regfile,
    output logic       o_load_mar,
    output logic       o_load_mdr,
    output logic       o_load_cc,
    output logic [1:0] o_pcmux_sel,
    output logic       o_storemux_sel,
    output logic       o_alumux_sel,
    output logic       o_regfilemux_sel,
    output logic       o_marmux_sel,
    output logic       o_mdrmux_sel,
    output logic [2:0] o_aluop,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic [1:0] o_mem_byte_enable
);

    typedef enum logic [3:0] {
        StFetch1   = 4'd0,
        StFetch2   = 4'd1,
        StFetch3   = 4'd2,
        StDecode   = 4'd3,
        StAdd      = 4'd4,
        StAnd      = 4'd5,
        StNot      = 4'd6,
        StBr       = 4'd7,
        StBrTaken  = 4'd8,
        StJmp      = 4'd9,
        StCalcAddr = 4'd10,
        StLdr1     = 4'd11,
        StLdr2     = 4'd12,
        StStr1     = 4'd13,
        StStr2     = 4'd14
    } state_e;

    state_e r_state;

    // State register and transition logic. Memory-wait states hold until i_mem_resp;
    // a response arriving in any other state has no effect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StFetch1;
        end else begin
            case (r_state)
                StFetch1: r_state <= StFetch2;
                StFetch2: if (i_mem_resp) r_state <= StFetch3;
                StFetch3: r_state <= StDecode;
                StDecode: begin
                    case (i_opcode)
                        OpAdd:        r_state <= StAdd;
                        OpAnd:        r_state <= StAnd;
                        OpNot:        r_state <= StNot;
                        OpBr:         r_state <= StBr;
                        OpJmp:        r_state <= StJmp;
                        OpLdr, OpStr: r_state <= StCalcAddr;
                        default:      r_state <= StFetch1;  // unimplemented opcode: NOP
                    endcase
                end
                StAdd, StAnd, StNot: r_state <= StFetch1;
                StBr:       r_state <= i_branch_enable ? StBrTaken : StFetch1;
                StBrTaken:  r_state <= StFetch1;
                StJmp:      r_state <= StFetch1;
                StCalcAddr: begin
                    case (i_opcode)
                        OpLdr:   r_state <= StLdr1;
                        OpStr:   r_state <= StStr1;
                        default: r_state <= StFetch1;
                    endcase
                end
                StLdr1: if (i_mem_resp) r_state <= StLdr2;
                StLdr2: r_state <= StFetch1;
                StStr1: r_state <= StStr2;
                StStr2: if (i_mem_resp) r_state <= StFetch1;
                default: r_state <= StFetch1;  // unused encoding recovers to fetch
            endcase
        end
    end

    // Moore output decode. Reset gates everything combinationally so strobes drop
    // in the same cycle a mid-access reset is asserted.
    always_comb begin
        o_load_pc         = 1'b0;
        o_load_ir         = 1'b0;
        o_load_regfile    = 1'b0;
        o_load_mar        = 1'b0;
        o_load_mdr        = 1'b0;
        o_load_cc         = 1'b0;
        o_pcmux_sel       = 2'b00;
        o_storemux_sel    = 1'b0;
        o_alumux_sel      = 1'b0;
        o_regfilemux_sel  = 1'b0;
        o_marmux_sel      = 1'b0;
        o_mdrmux_sel      = 1'b0;
        o_aluop           = AluAdd;
        o_mem_read        = 1'b0;
        o_mem_write       = 1'b0;
        o_mem_byte_enable = 2'b11;

        case (r_state)
            StFetch1: begin
                o_marmux_sel = 1'b1;
                o_load_mar   = 1'b1;
                o_load_pc    = 1'b1;
            end
            StFetch2, StLdr1: begin
                o_mem_read   = 1'b1;
                o_mdrmux_sel = 1'b1;
                o_load_mdr   = 1'b1;
            end
            StFetch3: o_load_ir = 1'b1;
            StAdd: begin
                o_load_regfile = 1'b1;
                o_load_cc      = 1'b1;
            end
            StAnd: begin
                o_aluop        = AluAnd;
                o_load_regfile = 1'b1;
                o_load_cc      = 1'b1;
            end
            StNot: begin
                o_aluop        = AluNot;
                o_load_regfile = 1'b1;
                o_load_cc      = 1'b1;
            end
            StBrTaken: begin
                o_pcmux_sel = 2'b01;
                o_load_pc   = 1'b1;
            end
            StJmp: begin
                o_pcmux_sel = 2'b10;
                o_load_pc   = 1'b1;
            end
            StCalcAddr: begin
                o_alumux_sel = 1'b1;
                o_load_mar   = 1'b1;
            end
            StLdr2: begin
                o_regfilemux_sel = 1'b1;
                o_load_regfile   = 1'b1;
                o_load_cc        = 1'b1;
            end
            StStr1: begin
                o_storemux_sel = 1'b1;
                o_aluop        = AluPass;
                o_load_mdr     = 1'b1;
            end
            StStr2: o_mem_write = 1'b1;
            default: ;
        endcase

        if (i_reset) begin
            o_load_pc         = 1'b0;
            o_load_ir         = 1'b0;
            o_load_regfile    = 1'b0;
            o_load_mar        = 1'b0;
            o_load_mdr        = 1'b0;
            o_load_cc         = 1'b0;
            o_pcmux_sel       = 2'b00;
            o_storemux_sel    = 1'b0;
            o_alumux_sel      = 1'b0;
            o_regfilemux_sel  = 1'b0;
            o_marmux_sel      = 1'b0;
            o_mdrmux_sel      = 1'b0;
            o_aluop           = 3'b000;
            o_mem_read        = 1'b0;
            o_mem_write       = 1'b0;
            o_mem_byte_enable = 2'b00;
        end
    end

endmodule
